upcc_ctrl: RTL

- Sequential control stage that closes the loop around the upcc next-state logic.
- Holds the 3-bit state register, drives the current state (outea) and direction (outup) to the next-state block, and captures that block's next state (inpe) on each advance.
- An advance comes from a debounced manual step button or from an auto-run prescaler.
- Also produces an advance pulse and an active-low 7-segment display of the current state.

---
 rtl/upcc_pkg.sv | 28 ++
 rtl/upcc_ctrl_if.sv | 16 +
 rtl/upcc_debounce.sv | 114 +++++++++++
 rtl/upcc_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/upcc_pkg.sv
// Shared types and constants for the upcc control stage.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package upcc_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Debouncer phases: waiting, qualifying a press, accepted, qualifying a release.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } db_state_e;

    // Active-low gfedcba patterns for digits 0..7.
    localparam logic [6:0] SEG_PAT [0:7] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    function automatic logic [6:0] seg_of(input state_t s);
        return SEG_PAT[s];
    endfunction

endpackage

// File: rtl/upcc_ctrl_if.sv
// Link between the control stage and the combinational next-state block.
// Latency: wires only; outputs of the master side are registered in the control stage.
// Backpressure: none, the next-state block must answer combinationally.
interface upcc_ctrl_if;
    import upcc_pkg::*;

    state_t     inpe;     // next state proposed by the next-state block
    state_t     outea;    // current state
    logic       outup;    // count direction, 1 = up
    logic       outtick;  // first cycle of a new state
    logic [6:0] outseg;   // active-low 7-segment image of outea

    modport master (input inpe, output outea, outup, outtick, outseg);
    modport slave  (output inpe, input outea, outup, outtick, outseg);

endinterface

// File: rtl/upcc_debounce.sv
// Button conditioner: 2-flop synchronizer plus press/release qualifier (UPCC_CTRL_DEBOUNCE_EN), else plain edge detect.
// Latency: raw edge to rise pulse 2+DEB_CYCLES cycles with the qualifier, 3 cycles without it.
// Backpressure: none; rise is a single-cycle pulse that is never held off.
module upcc_debounce
    import upcc_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic inclk,
    input  logic inrst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;
    logic       sync;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], raw};
    end

    assign sync = sync_q[1];

`ifdef UPCC_CTRL_DEBOUNCE_EN

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    db_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Qualifier state and stability counter.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state: a level is accepted only after it has been steady for the full window.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        rise  = 1'b0;
        case (st_q)
            IDLE: begin
                if (sync) begin
                    st_d  = PRESS;
                    cnt_d = '0;
                end
            end
            PRESS: begin
                if (!sync) begin
                    st_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    st_d = HELD;
                    rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    st_d  = RELEASE;
                    cnt_d = '0;
                end
            end
            RELEASE: begin
                if (sync) begin
                    st_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    st_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign level = (st_q == HELD) || (st_q == RELEASE);

`else

    // Window length has no meaning without the qualifier.
    logic unused_deb_cycles;
    assign unused_deb_cycles = (DEB_CYCLES != 0);

    logic sync_d;
    logic rise_q;

    // Registered rising-edge detect on the synchronized level.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            sync_d <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_d <= sync;
            rise_q <= sync & ~sync_d;
        end
    end

    assign level = sync;
    assign rise  = rise_q;

`endif

endmodule

// File: rtl/upcc_ctrl.sv
// upcc control stage: state register, step/auto advance, direction and 7-seg decode; option macro UPCC_CTRL_DEBOUNCE_EN.
// Latency: rise pulse or auto tick to new outea/outtick/outseg 1 cycle; load 1 cycle.
// Backpressure: none; the next-state block is sampled combinationally on every advance.
module upcc_ctrl
    import upcc_pkg::*;
#(
    parameter int     DEB_CYCLES  = 16,
    parameter int     PRESCALE    = 50,
    parameter state_t RESET_STATE = 3'b000
) (
    input  logic        inclk,
    input  logic        inrst_n,
    input  logic        instep,
    input  logic        inup_btn,
    input  logic        inauto,
    input  logic        inload,
    input  state_t      inload_val,
    upcc_ctrl_if.master nsl
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic            step_rise;
    logic            unused_step_level;
    logic            up_level;
    logic            unused_up_rise;
    logic [PS_W-1:0] ps_q;
    logic            auto_tick;
    logic            adv;
    state_t          ea_q;
    state_t          ea_nxt;
    logic            up_q;
    logic            tick_q;
    logic [6:0]      seg_q;

    upcc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_db (
        .inclk   (inclk),
        .inrst_n (inrst_n),
        .raw     (instep),
        .level   (unused_step_level),
        .rise    (step_rise)
    );

    upcc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up_db (
        .inclk   (inclk),
        .inrst_n (inrst_n),
        .raw     (inup_btn),
        .level   (up_level),
        .rise    (unused_up_rise)
    );

    // A manual step and an auto tick in the same cycle merge into a single advance.
    assign auto_tick = inauto && (ps_q == PS_LAST);
    assign adv       = step_rise || auto_tick;

    // Prescaler restarts on any state change so auto-run spacing is measured from the last update.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n)                      ps_q <= '0;
        else if (inload || adv || !inauto) ps_q <= '0;
        else                               ps_q <= ps_q + 1'b1;
    end

    // Load beats advance; an advance takes the next-state block's answer.
    always_comb begin
        ea_nxt = ea_q;
        if (inload)   ea_nxt = inload_val;
        else if (adv) ea_nxt = nsl.inpe;
    end

    // State, tick and display registers; direction only moves when inpe is not being captured.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            ea_q   <= RESET_STATE;
            up_q   <= 1'b1;
            tick_q <= 1'b0;
            seg_q  <= seg_of(RESET_STATE);
        end else begin
            ea_q   <= ea_nxt;
            tick_q <= inload || adv;
            seg_q  <= seg_of(ea_nxt);
            if (!adv && !inload) up_q <= up_level;
        end
    end

    assign nsl.outea   = ea_q;
    assign nsl.outup   = up_q;
    assign nsl.outtick = tick_q;
    assign nsl.outseg  = seg_q;

endmodule
